// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared types and helpers for the UART transmit path.
//   - tx_state_t     : serializer FSM states
//   - UART_DATA_BITS : data bits per frame
//   - bit_cycles()   : clocks per bit time (truncating divide)
//   The PARITY state is always enumerated. The FSM only uses it when
//   UART_TX_PARITY_EN is defined.
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO. dout_o always shows the head
//   entry. A push into a full FIFO is dropped, even when a pop happens in the
//   same cycle. A pop from an empty FIFO is ignored.
//   Ports:
//     clk, rst_n        clock and asynchronous active-low reset (flushes the FIFO)
//     push_i, din_i     write request and data
//     pop_i             remove the head entry
//     dout_o            head entry
//     full_o, empty_o   status flags
//     count_o           number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // The storage array has no reset. Only the pointers and the count define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter with a byte queue. Bytes are queued in sync_fifo and sent
//   LSB-first on uart_tx. The default frame is 8N1 (10 bit times).
//   Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
//   between the data bits and the stop bit (11 bit times).
//   Ports:
//     clk, rst_n          system clock and asynchronous active-low reset
//     tx_data, tx_valid   byte to queue and its valid strobe
//     tx_ready            queue not full; a byte is taken when tx_valid & tx_ready
//     uart_tx             serial line, idle high, registered
//     tx_busy             a frame is in progress or the queue is non-empty
//     fifo_count          queued bytes; excludes the byte being shifted
// ----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          uart_tx,
    output logic          tx_busy,
    output logic [CW-1:0] fifo_count
);

    localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam int BW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic          pop;
    logic [7:0]    head;
    logic          full, empty;
    logic [CW-1:0] count;
    logic [CW-1:0] cnt_nxt;
    logic          push_ok;
    logic          bit_done;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_valid),
        .din_i   (tx_data),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign tx_ready   = ~full;
    assign push_ok    = tx_valid & ~full;
    assign fifo_count = count;
    assign uart_tx    = tx_q;
    assign tx_busy    = busy_q;
    assign bit_done   = (baud_q == BW'(BIT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = bit_done ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                // Pop straight from STOP so that consecutive frames have no idle gap.
                if (bit_done) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^head;
`endif
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line is registered from the current state. It therefore trails the
    // state by one clock: the pop edge is followed by the falling edge of the
    // start bit on the next clock edge. Every bit keeps its full length.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // Compute busy from next-state values so that the registered output matches
    // (state != IDLE) | (count != 0) after each edge without combinational glitches.
    always_comb begin
        case ({push_ok, pop})
            2'b10:   cnt_nxt = count + 1'b1;
            2'b01:   cnt_nxt = count - 1'b1;
            default: cnt_nxt = count;
        endcase
    end
    assign busy_d = (state_d != IDLE) | (cnt_nxt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo. The DUT runs at a reduced bit time
//   (16 clocks per bit) to keep the run short. An independent line sampler
//   decodes frames at mid-bit and compares each byte with a queue of accepted
//   bytes. Define UART_TX_PARITY_EN to exercise the parity build.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int DEPTH    = 16;
    localparam int CW       = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int BUDGET = 20 * FRAME * BIT;

    logic          clk = 0;
    logic          rst_n = 0;
    logic [7:0]    tx_data = '0;
    logic          tx_valid = 0;
    logic          tx_ready, uart_tx, tx_busy;
    logic [CW-1:0] fifo_count;

    int   checks = 0, errors = 0;
    int   cyc = 0;
    int   viol = 0;
    int   rx_cnt = 0, tx_cnt = 0;
    bit   rx_en = 1;
    bit   rx_busy = 0;
    bit   par_last;
    int   n_acc;
    logic [7:0] exp_q[$];
    int   st_q[$];

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // tx_ready must equal (fifo_count != DEPTH) at all times outside reset.
    always @(negedge clk)
        if (rst_n && (tx_ready !== (fifo_count != CW'(DEPTH)) || fifo_count > CW'(DEPTH))) viol++;

    // Mid-bit line sampler, used as the reference receiver.
    initial begin
        logic s_start, s_stop, s_par;
        logic [7:0] rb;
        forever begin
            @(negedge clk);
            if (rst_n && !uart_tx) begin
                rx_busy = 1;
                st_q.push_back(cyc);
                repeat (BIT / 2) @(negedge clk);
                s_start = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    rb[i] = uart_tx;
                end
                s_par = 1'b0;
`ifdef UART_TX_PARITY_EN
                repeat (BIT) @(negedge clk);
                s_par = uart_tx;
`endif
                repeat (BIT) @(negedge clk);
                s_stop = uart_tx;
                if (rx_en) begin
                    chk("start_bit", s_start, 0);
                    chk("stop_bit", s_stop, 1);
`ifdef UART_TX_PARITY_EN
                    chk("parity", s_par, ^rb);
`endif
                    par_last = s_par;
                    if (exp_q.size() == 0) chk("extra_byte", rb, 32'hFFFF_FFFF);
                    else chk("rx_byte", rb, exp_q.pop_front());
                    rx_cnt++;
                end
                rx_busy = 0;
            end
        end
    end

    // Drive one byte and hold tx_valid until the DUT takes it. n_acc is set to the accept edge.
    task automatic push(input logic [7:0] b);
        int w;
        w = 0;
        tx_data  = b;
        tx_valid = 1;
        @(negedge clk);
        while (!tx_ready && w < BUDGET) begin
            @(negedge clk);
            w++;
        end
        if (!tx_ready) chk("push_timeout", 1, 0);
        else begin
            if (rx_en) begin
                exp_q.push_back(b);
                tx_cnt++;
            end
        end
        @(posedge clk);
        #1;
        n_acc    = cyc;
        tx_valid = 0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((tx_busy || rx_busy) && w < BUDGET) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (tx_busy || rx_busy) chk("drain_timeout", 1, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n, w;
        #1;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_line", uart_tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", tx_ready, 1);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;

        // 1: single byte 0x55, latency, bit length and busy duration
        push(8'h55);
        n = n_acc;
        chk("t1_line_N", uart_tx, 1);
        chk("t1_cnt_N", fifo_count, 1);
        chk("t1_busy_N", tx_busy, 1);
        @(posedge clk); #1;
        chk("t1_line_N1", uart_tx, 1);
        chk("t1_cnt_N1", fifo_count, 0);
        @(posedge clk); #1;
        chk("t1_line_N2", uart_tx, 0);
        repeat (BIT - 1) @(posedge clk);
        #1;
        chk("t1_start_end", uart_tx, 0);
        @(posedge clk); #1;
        chk("t1_bit0", uart_tx, 1);
        w = 0;
        while (tx_busy && w < BUDGET) begin
            @(posedge clk); #1;
            w++;
        end
        chk("t1_busy_len", cyc - n, 1 + FRAME * BIT);
        drain();

        // 2: back-to-back "AB", no gap between frames
        st_q.delete();
        push(8'h41);
        push(8'h42);
        drain();
        chk("t2_frames", st_q.size(), 2);
        if (st_q.size() == 2) chk("t2_gap", st_q[1] - st_q[0], FRAME * BIT);

        // 3: fill to full with tx_valid held; the 18th byte waits for space
        for (int i = 0; i < 17; i++) push(8'(8'h60 + i));
        chk("t3_full_cnt", fifo_count, DEPTH);
        chk("t3_full_rdy", tx_ready, 0);
        push(8'hEE);
        drain();
        chk("t3_left", exp_q.size(), 0);

        // 4: reset during data bit 3 of 0xA5
        rx_en = 0;
        push(8'hA5);
        repeat (2 + 4 * BIT + BIT / 2 - 1) @(posedge clk);
        #1;
        chk("t4_bit3", uart_tx, 0);
        rst_n = 0;
        #1;
        chk("t4_line", uart_tx, 1);
        chk("t4_cnt", fifo_count, 0);
        chk("t4_busy", tx_busy, 0);
        chk("t4_ready", tx_ready, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        repeat (2 * FRAME * BIT) @(posedge clk);
        #1;
        rx_en = 1;
        push(8'h3C);
        drain();

`ifdef UART_TX_PARITY_EN
        // 5: parity values
        push(8'h07);
        drain();
        chk("t5_par07", par_last, 1);
        push(8'h03);
        drain();
        chk("t5_par03", par_last, 0);
`endif

        // 6: loopback bytes
        push(8'h31);
        push(8'h0A);
        drain();

        // Random bytes with random gaps
        for (int i = 0; i < 24; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
        end
        drain();

        chk("rx_total", rx_cnt, tx_cnt);
        chk("exp_empty", exp_q.size(), 0);
        chk("ready_rule", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
